prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_sync_edge.sv | 27 ++
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared CPU definitions: mode/state encoding and memory port widths.
package prog_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Encoding is shared with the control unit through cpustate.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IN    = 2'b01,
    ST_CHECK = 2'b10,
    ST_RUN   = 2'b11
  } cpu_state_e;

endpackage

// File: rtl/prog_loader_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous operator button. rise_o is high for one clk per press.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  // Metastability chain plus one flop of history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: lets an operator key bytes into program
// memory (IN), step through it for display (CHECK) and hand the memory
// port to the CPU (RUN).
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode_sw,
  input  logic              step_btn,
  input  logic [DATA_W-1:0] data_sw,
  output logic [1:0]        cpustate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              bus_own,
  output logic              cpu_rst_n
);

  cpu_state_e state_q, state_d;
  logic [1:0] mode_s1_q, mode_s2_q;
  data_t      data_s1_q, data_s2_q;
  addr_t      cnt_q, cnt_d;
  data_t      wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       own_q, own_d;
  logic       rstn_q, rstn_d;
  logic       step_rise;
  logic       chg;

  sync_edge u_step_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (step_btn),
    .rise_o (step_rise)
  );

  // Plain synchronizers for the level-type switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_s1_q <= 2'b00;
      mode_s2_q <= 2'b00;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      mode_s1_q <= mode_sw;
      mode_s2_q <= mode_s1_q;
      data_s1_q <= data_sw;
      data_s2_q <= data_s1_q;
    end
  end

  // State and registered outputs; reset also kills an in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      own_q   <= 1'b1;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      own_q   <= own_d;
      rstn_q  <= rstn_d;
    end
  end

  // Next state follows the synchronized switch; a mode change clears the
  // counter and swallows any coincident step. A write's address advance
  // lands on the edge that ends the strobe cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    chg     = (mode_s2_q != state_q);
    if (chg) begin
      state_d = cpu_state_e'(mode_s2_q);
      cnt_d   = '0;
    end else begin
      if (we_q) cnt_d = cnt_q + 8'd1;
      if (step_rise) begin
        case (state_q)
          ST_IN: begin
            we_d    = 1'b1;
            wdata_d = data_s2_q;
          end
          ST_CHECK: cnt_d = cnt_q + 8'd1;
          default: ;
        endcase
      end
    end
    re_d   = (state_d == ST_CHECK);
    own_d  = (state_d != ST_RUN);
    // Run enable trails RUN entry by a cycle so the bus is already handed over.
    rstn_d = (state_q == ST_RUN) && !chg;
  end

  assign cpustate  = state_q;
  assign mem_addr  = cnt_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign bus_own   = own_q;
  assign cpu_rst_n = rstn_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: cycle model of the loader's rules plus directed
// scenarios with literal expectations.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode_sw = 2'b00;
  logic       step_btn = 1'b0;
  logic [7:0] data_sw = 8'h00;
  logic [1:0] cpustate;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_we, mem_re, bus_own, cpu_rst_n;

  int passed = 0;
  int total  = 0;
  int we_cnt = 0;
  bit cmp_en = 0;
  bit pair_chk = 0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .mode_sw(mode_sw), .step_btn(step_btn),
    .data_sw(data_sw), .cpustate(cpustate), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .bus_own(bus_own), .cpu_rst_n(cpu_rst_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
  endtask

  // Model: inputs sampled at each edge; the loader reacts to what it
  // sampled two edges earlier (step edge = sample k-2 high, k-3 low).
  logic [1:0] mh [0:3];
  logic       sh [0:3];
  logic [7:0] dh [0:3];
  logic [1:0] m_st = 2'd0;
  logic [7:0] m_cnt = 8'd0, m_wd = 8'd0;
  logic       m_we = 0, m_re = 0, m_own = 1, m_rstn = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin mh[j] = 0; sh[j] = 0; dh[j] = 0; end
      m_st = 0; m_cnt = 0; m_wd = 0; m_we = 0; m_re = 0; m_own = 1; m_rstn = 0;
    end else begin
      logic moved, step;
      for (int j = 3; j > 0; j--) begin mh[j] = mh[j-1]; sh[j] = sh[j-1]; dh[j] = dh[j-1]; end
      mh[0] = mode_sw; sh[0] = step_btn; dh[0] = data_sw;
      moved  = (mh[2] != m_st);
      step   = sh[2] && !sh[3];
      m_rstn = (m_st == 2'd3) && !moved;
      if (moved) begin
        m_cnt = 0;
        m_we  = 0;
      end else begin
        if (m_we) m_cnt = m_cnt + 8'd1;
        m_we = 0;
        if (step && m_st == 2'd1) begin m_we = 1; m_wd = dh[2]; end
        if (step && m_st == 2'd2) m_cnt = m_cnt + 8'd1;
      end
      m_st  = mh[2];
      m_re  = (m_st == 2'd2);
      m_own = (m_st != 2'd3);
    end
  end

  // Every cycle: DUT against model, plus strobe bookkeeping.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cpustate", cpustate, m_st);
      chk("mem_addr", mem_addr, m_cnt);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
      chk("mem_re", mem_re, m_re);
      chk("bus_own", bus_own, m_own);
      chk("cpu_rst_n", cpu_rst_n, m_rstn);
      if (!bus_own) chk("no_mem_when_cpu", {mem_we, mem_re}, 2'b00);
    end
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (pair_chk) chk("wr_addr_eq_data", mem_wdata, mem_addr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    @(negedge clk); #1 step_btn = 1'b1;
    cyc(hold);
    #1 step_btn = 1'b0;
    cyc(3);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk); #1 mode_sw = m;
    cyc(4);
  endtask

  int lat, base;

  initial begin
    // Reset state, with a non-idle mode request already present.
    mode_sw = 2'b01;
    #12;
    chk("rst_cpustate", cpustate, 2'b00);
    chk("rst_bus_own", bus_own, 1'b1);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    @(negedge clk); #1 reset = 1'b1;
    cmp_en = 1;
    cyc(1);
    chk("idle_after_release", cpustate, 2'b00);

    // First write: 0x1A to address 0, three clocks after the press.
    data_sw = 8'h1A;
    cyc(4);
    chk("in_state", cpustate, 2'b01);
    @(negedge clk); #1 step_btn = 1'b1;
    lat = 0;
    while (mem_we !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    chk("step_latency", lat, 3);
    chk("w1_addr", mem_addr, 8'h00);
    chk("w1_data", mem_wdata, 8'h1A);
    @(negedge clk);
    chk("w1_strobe_single", mem_we, 1'b0);
    chk("w1_cnt_after", mem_addr, 8'h01);
    #1 step_btn = 1'b0;
    cyc(3);

    // Full address sweep with data = address, ending in a wrap.
    set_mode(2'b00);
    set_mode(2'b01);
    base = we_cnt;
    pair_chk = 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1 data_sw = i[7:0];
      press(1);
    end
    cyc(5);
    pair_chk = 0;
    chk("sweep_writes", we_cnt - base, 256);
    chk("sweep_wrap", mem_addr, 8'h00);

    // IN -> CHECK with a coincident step: step is lost, counter cleared.
    press(1);
    chk("pre_chk_cnt", mem_addr, 8'h01);
    base = we_cnt;
    @(negedge clk); #1 mode_sw = 2'b10; step_btn = 1'b1;
    cyc(5);
    #1 step_btn = 1'b0;
    cyc(2);
    chk("chg_no_write", we_cnt - base, 0);
    chk("chg_state", cpustate, 2'b10);
    chk("chg_cnt", mem_addr, 8'h00);
    chk("chg_re", mem_re, 1'b1);
    press(1);
    chk("check_step", mem_addr, 8'h01);
    chk("check_no_we", we_cnt - base, 0);

    // RUN: bus handed over, run enable one cycle after entry.
    @(negedge clk); #1 mode_sw = 2'b11;
    lat = 0;
    while (cpustate !== 2'b11 && lat < 10) begin @(negedge clk); lat++; end
    chk("run_entry_lat", lat, 3);
    chk("run_bus_own", bus_own, 1'b0);
    chk("run_mem_re", mem_re, 1'b0);
    chk("run_rstn_entry", cpu_rst_n, 1'b0);
    @(negedge clk);
    chk("run_rstn_next", cpu_rst_n, 1'b1);
    press(1);
    press(2);
    chk("run_no_write", we_cnt - base, 0);

    // Long hold gives exactly one write.
    set_mode(2'b01);
    base = we_cnt;
    press(50);
    chk("hold_one_write", we_cnt - base, 1);

    // Reset in the middle of a strobe cycle.
    @(negedge clk); #1 step_btn = 1'b1;
    lat = 0;
    while (mem_we !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    chk("pre_abort_we", mem_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_state", cpustate, 2'b00);
    chk("abort_rstn", cpu_rst_n, 1'b0);
    chk("abort_cnt", mem_addr, 8'h00);
    chk("abort_own", bus_own, 1'b1);
    step_btn = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    cyc(5);
    chk("post_rst_follow", cpustate, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
